// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit:
// funct3 access codes, the ResultSrc load code and the FSM state type.
package mem_stage_lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] RS_LOAD = 2'b01;

   typedef enum logic {
      IDLE,
      WAIT
   } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational store lane steering / byte enables and
// load byte/half extract with sign or zero extension.
// Ports: funct3, addr_lo, store, wdata, rdata in; be, wdata_lane, rdata_ext out.
module lsu_align
   import mem_stage_lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic        store,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);

   logic [31:0] sh;

   // Replicating the store data lets the byte enables pick the lane.
   always_comb begin
      be         = 4'b1111;
      wdata_lane = wdata;
      if (store) begin
         case (funct3[1:0])
            2'b00: begin
               be         = 4'b0001 << addr_lo;
               wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
               be         = 4'b0011 << addr_lo;
               wdata_lane = {2{wdata[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // Align the addressed byte/half down to bit 0 before extending.
   assign sh = rdata >> {addr_lo, 3'b000};

   always_comb begin
      rdata_ext = rdata;
      unique case (1'b1)
         (funct3 == F3_LB):  rdata_ext = {{24{sh[7]}}, sh[7:0]};
         (funct3 == F3_LH):  rdata_ext = {{16{sh[15]}}, sh[15:0]};
         (funct3 == F3_LBU): rdata_ext = {24'h0, sh[7:0]};
         (funct3 == F3_LHU): rdata_ext = {16'h0, sh[15:0]};
         default:            rdata_ext = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory stage with req/ack data-memory handshake,
// timeout abort, misalignment drop, stall generation and MEM/WB register.
// Ports: EX/MEM ...M inputs, mem_* bus, StallM, pulses, MEM/WB ...W outputs.
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int XLEN    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWriteM,
   input  logic [1:0]      ResultSrcM,
   input  logic            MemWriteM,
   input  logic [2:0]      funct3M,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] WriteDataM,
   input  logic [4:0]      RdM,
   input  logic [XLEN-1:0] PCPlus4M,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack,
   output logic            StallM,
   output logic            misaligned,
   output logic            bus_error,
   output logic            RegWriteW,
   output logic [1:0]      ResultSrcW,
   output logic [4:0]      RdW,
   output logic [XLEN-1:0] ALUResultW,
   output logic [XLEN-1:0] ReadDataW,
   output logic [XLEN-1:0] PCPlus4W
);

   localparam int CW = $clog2(TIMEOUT + 1);

   lsu_state_t      state;
   logic [CW-1:0]   cnt;
   logic            load;
   logic            store;
   logic            access;
   logic            mis;
   logic            timeout_hit;
   logic            done;
   logic [XLEN-1:0] rdata_ext;

   assign load   = (ResultSrcM == RS_LOAD);
   assign store  = MemWriteM;
   assign access = load | store;

   assign mis = access &
      (((funct3M[1:0] == 2'b01) & ALUResultM[0]) |
       ((funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00)));

   // Gated by rst so an abandoned access drops off the bus at once.
   assign mem_req = rst &
      (((state == IDLE) & access & ~mis) | (state == WAIT));

   assign timeout_hit = (state == WAIT) & ~mem_ack &
                        (cnt == CW'(TIMEOUT - 1));

   assign done     = mem_req & mem_ack;
   assign StallM   = mem_req & ~mem_ack & ~timeout_hit;
   assign mem_we   = store;
   assign mem_addr = {ALUResultM[XLEN-1:2], 2'b00};

   lsu_align u_align (
      .funct3     (funct3M),
      .addr_lo    (ALUResultM[1:0]),
      .store      (store),
      .wdata      (WriteDataM),
      .rdata      (mem_rdata),
      .be         (mem_be),
      .wdata_lane (mem_wdata),
      .rdata_ext  (rdata_ext)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (mem_req & ~mem_ack) begin
                  state <= WAIT;
                  cnt   <= CW'(1);
               end
            end
            WAIT: begin
               if (mem_ack | timeout_hit) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= '0;
         RdW        <= '0;
         ALUResultW <= '0;
         ReadDataW  <= '0;
         PCPlus4W   <= '0;
         misaligned <= 1'b0;
         bus_error  <= 1'b0;
      end else begin
         misaligned <= mis;
         bus_error  <= timeout_hit;
         if (!access || done) begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            RdW        <= RdM;
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            if (done && load)
               ReadDataW <= rdata_ext;
         end else begin
            // Stall, timeout or misaligned drop: bubble, hold the rest.
            RegWriteW <= 1'b0;
         end
      end
   end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit; consumes the EX/MEM pipeline register outputs (…M signals) and drives the MEM/WB register, which is integrated here (…W outputs).
- Runs a req/ack handshake to data memory with variable latency.
- Performs byte/half/word store lane steering and load sign/zero extension.
- Raises StallM to freeze upstream stages while an access is outstanding; a timeout aborts a hung access.

Parameters:
TIMEOUT, 16, max cycles an access may wait for mem_ack before abort (>=2)
XLEN, 32, datapath width (only 32 supported)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
RegWriteM  in  1  register write enable from EX/MEM
ResultSrcM  in  2  result select; 2'b01 = load
MemWriteM  in  1  store enable
funct3M  in  3  access size/sign (RISC-V funct3)
ALUResultM  in  32  effective address / ALU result
WriteDataM  in  32  store data
RdM  in  5  destination register
PCPlus4M  in  32  PC+4
mem_req  out  1  access request
mem_we  out  1  1 = write
mem_addr  out  32  {ALUResultM[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-steered store data
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  access complete
StallM  out  1  hold PC/IF/ID/EX/EM registers
misaligned  out  1  one-cycle pulse, misaligned access dropped
bus_error  out  1  one-cycle pulse, access timed out
RegWriteW, ResultSrcW[1:0], RdW[4:0], ALUResultW[31:0], ReadDataW[31:0], PCPlus4W[31:0]  out  -  MEM/WB register

Behaviour:
- Reset:
  - Asynchronous, active-low on rst.
  - State IDLE, timeout counter 0.
  - All …W outputs 0; misaligned, bus_error 0.
  - mem_req and StallM go low immediately, even mid-access; any in-flight access is abandoned.
- Access decode:
  - load = (ResultSrcM==2'b01); store = MemWriteM; access = load|store.
  - Misaligned if size=half and addr[0]=1, or size=word and addr[1:0]!=0.
- States: IDLE, WAIT.
- mem_req = (IDLE & access & aligned) | WAIT. This is combinational, so a zero-wait access completes in its first cycle.
- mem_we = store.
- StallM = mem_req & ~mem_ack & ~timeout_hit.
- Transitions:
  - IDLE -> WAIT when the request is issued and mem_ack=0; counter loads 1.
  - WAIT -> IDLE on mem_ack, or on timeout_hit (counter==TIMEOUT-1 & ~mem_ack). Otherwise the counter increments.
  - mem_ack is ignored while mem_req=0.
- Store steering, by funct3[1:0]:
  - SB: be = 1<<addr[1:0]; wdata = byte replicated x4.
  - SH: be = 4'b0011<<addr[1:0]; wdata = half replicated x2.
  - SW: be = 4'b1111; wdata unchanged.
  - Loads drive be=4'b1111.
- Load extension:
  - Byte/half selected from mem_rdata by addr[1:0].
  - funct3 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero.
- MEM/WB update, every clock edge:
  - Non-access instruction: pass RegWriteM, ResultSrcM, RdM, ALUResultM, PCPlus4M; ReadDataW keeps its old value.
  - Access completing (mem_ack & mem_req): pass all fields; for a load, ReadDataW = extended data.
  - Stalled cycle: bubble, RegWriteW=0; other W fields hold.
  - Misaligned access: no request, no stall, bubble, misaligned=1 for that cycle.
  - Timeout: bubble, bus_error=1 for that cycle, StallM low so the pipeline advances.
- Integration: the EX/MEM register must hold while StallM=1, so the address and data stay stable through WAIT.

Decomposition:
- Shared package: funct3 encodings (LB..LHU, SB..SW), the ResultSrc load code, and the state enum.
- One sub-module, lsu_align: purely combinational store steering/byte enables and load extract/extension.
- FSM, timeout counter and MEM/WB register stay in mem_stage_lsu.

Test Plan:
- LW at 0x100, mem_ack same cycle, rdata=0xDEADBEEF -> StallM never high; next edge ReadDataW=0xDEADBEEF, RegWriteW=1.
- LB at 0x103, ack after 3 cycles, rdata=0x80XXXXXX -> StallM high 3 cycles with RegWriteW=0 bubbles, then ReadDataW=0xFFFFFF80. LBU same case -> 0x00000080.
- SH at 0x202, WriteDataM=0x1234ABCD -> mem_addr=0x200, be=4'b1100, wdata=0xABCDABCD, mem_we=1.
- LW at 0x101 -> mem_req stays 0; misaligned pulses 1 cycle; RegWriteW=0; no stall.
- Load with no mem_ack, TIMEOUT=4 -> StallM high 3 cycles, bus_error pulse on the 4th, state returns to IDLE, bubble written.
- rst driven low during WAIT -> mem_req, StallM and RegWriteW go 0 immediately; after release the next ALU op (RdM=5, ALUResultM=7) passes to RdW=5, ALUResultW=7.
